// File: rtl/crc_sig_checker.sv
// Response-signature checker: compacts a counted stream of 32-bit words into a
// MISR signature and reports a pass/fail verdict against a golden value.
module crc_sig_checker #(
    parameter logic [31:0] SEED  = 32'h0000_0000,
    parameter int          LEN_W = 16
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      golden_i,
    input  logic             data_valid_i,
    input  logic [31:0]      data_i,
    output logic             data_ready_o,
    output logic [31:0]      sig_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPACT,
        COMPARE,
        DONE
    } state_t;

    // Feedback taps into bits 3, 10 and 15 (bit 0 always takes the feedback).
    localparam logic [31:0] TAPS = 32'h0000_8408;

    state_t           state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] cnt_reg;
    logic [LEN_W-1:0] cnt_next;
    logic [31:0]      golden_reg;
    logic [31:0]      sig_reg;
    logic [31:0]      sig_next;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             pass_reg;
    logic             fail_reg;
    logic             fb;

    assign fb          = sig_reg[31];
    assign sig_next[0] = fb ^ data_i[0];
    assign cnt_next    = cnt_reg + 1'b1;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_misr
            assign sig_next[gi] = sig_reg[gi-1] ^ data_i[gi] ^ (TAPS[gi] & fb);
        end
    endgenerate

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            state_reg  <= IDLE;
            len_reg    <= '0;
            cnt_reg    <= '0;
            golden_reg <= '0;
            sig_reg    <= '0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            pass_reg   <= 1'b0;
            fail_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        len_reg    <= len_i;
                        golden_reg <= golden_i;
                        pass_reg   <= 1'b0;
                        fail_reg   <= 1'b0;
                        busy_reg   <= 1'b1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        sig_reg <= SEED;
                        cnt_reg <= '0;
                        if (len_reg != '0) begin
                            ready_reg <= 1'b1;
                            state_reg <= COMPACT;
                        end else begin
                            state_reg <= COMPARE;
                        end
                    end
                end
                COMPACT: begin
                    if (abort_i) begin
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (data_valid_i) begin
                        sig_reg <= sig_next;
                        cnt_reg <= cnt_next;
                        if (cnt_next == len_reg) begin
                            ready_reg <= 1'b0;
                            state_reg <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    busy_reg <= 1'b0;
                    if (abort_i) begin
                        state_reg <= IDLE;
                    end else begin
                        pass_reg  <= (sig_reg == golden_reg);
                        fail_reg  <= (sig_reg != golden_reg);
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_ready_o = ready_reg;
    assign sig_o        = sig_reg;
    assign busy_o       = busy_reg;
    assign done_o       = done_reg;
    assign pass_o       = pass_reg;
    assign fail_o       = fail_reg;

endmodule

// File: tb/tb_crc_sig_checker.sv
// Directed bench for crc_sig_checker: hand-computed signatures, verdicts,
// done latency, gap handling, abort and asynchronous reset behaviour.
module tb_crc_sig_checker;

    logic        CK;
    logic        RESET;
    logic        start_i;
    logic        abort_i;
    logic [15:0] len_i;
    logic [31:0] golden_i;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        data_ready_o;
    logic [31:0] sig_o;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic        fail_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    crc_sig_checker #(.SEED(32'h0000_0000), .LEN_W(16)) dut (
        .CK           (CK),
        .RESET        (RESET),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .len_i        (len_i),
        .golden_i     (golden_i),
        .data_valid_i (data_valid_i),
        .data_i       (data_i),
        .data_ready_o (data_ready_o),
        .sig_o        (sig_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_o       (pass_o),
        .fail_o       (fail_o)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    always @(posedge CK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; inputs are driven and outputs sampled at negedge.
    task automatic step;
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, busy_o},       32'd0);
        check({tag, "_ready"}, {31'd0, data_ready_o}, 32'd0);
        check({tag, "_done"},  {31'd0, done_o},       32'd0);
    endtask

    // Edge T accepts the start, edge T+1 leaves LOAD; returns at COMPACT.
    task automatic start_session(input logic [15:0] len, input logic [31:0] golden);
        start_i  = 1'b1;
        len_i    = len;
        golden_i = golden;
        step;
        t0       = cyc;
        start_i  = 1'b0;
        check("load_busy",  {31'd0, busy_o},       32'd1);
        check("load_ready", {31'd0, data_ready_o}, 32'd0);
        check("load_pass",  {31'd0, pass_o},       32'd0);
        check("load_fail",  {31'd0, fail_o},       32'd0);
        step;
    endtask

    task automatic send_word(input logic [31:0] d, input int gap, input logic [31:0] hold);
        for (int i = 0; i < gap; i++) begin
            data_valid_i = 1'b0;
            data_i       = 32'hA5A5_A5A5;
            step;
            check("gap_sig",   sig_o,                  hold);
            check("gap_ready", {31'd0, data_ready_o},  32'd1);
        end
        check("word_ready", {31'd0, data_ready_o}, 32'd1);
        data_valid_i = 1'b1;
        data_i       = d;
        step;
        data_valid_i = 1'b0;
        data_i       = 32'h0;
    endtask

    task automatic wait_done(input int exp_ofs, input logic exp_pass);
        int n = 0;
        while (done_o !== 1'b1 && n < 40) begin
            step;
            n++;
        end
        if (done_o !== 1'b1) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("done_latency", cyc - t0,          exp_ofs);
            check("verdict_pass", {31'd0, pass_o},   {31'd0, exp_pass});
            check("verdict_fail", {31'd0, fail_o},   {31'd0, ~exp_pass});
            $display("session done: ofs=%0d sig=0x%08h pass=%0d fail=%0d", cyc - t0, sig_o, pass_o, fail_o);
            step;
            check("done_pulse", {31'd0, done_o}, 32'd0);
            check("held_pass",  {31'd0, pass_o}, {31'd0, exp_pass});
            check("post_busy",  {31'd0, busy_o}, 32'd0);
        end
    endtask

    initial begin
        RESET        = 1'b1;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        len_i        = '0;
        golden_i     = '0;
        data_valid_i = 1'b0;
        data_i       = '0;
        step;
        step;
        check("rst_sig",  sig_o,             32'd0);
        check("rst_pass", {31'd0, pass_o},   32'd0);
        check("rst_fail", {31'd0, fail_o},   32'd0);
        check_idle_outputs("rst");
        RESET = 1'b0;
        step;

        // Reset asserted mid-COMPACT clears everything without a clock edge.
        start_session(16'd4, 32'h0);
        send_word(32'h0000_0001, 0, 32'h0);
        check("mid_sig", sig_o, 32'h0000_0001);
        #2 RESET = 1'b1;
        #1;
        check("arst_sig",  sig_o,           32'd0);
        check("arst_pass", {31'd0, pass_o}, 32'd0);
        check("arst_fail", {31'd0, fail_o}, 32'd0);
        check_idle_outputs("arst");
        @(negedge CK);
        RESET = 1'b0;
        step;
        check_idle_outputs("arst_idle");
        $display("session reset mid-compact");

        // Pass case: 1 then 0 -> 0x1, 0x2.
        start_session(16'd2, 32'h0000_0002);
        send_word(32'h0000_0001, 0, 32'h0);
        check("p_sig1", sig_o, 32'h0000_0001);
        send_word(32'h0000_0000, 0, 32'h0);
        check("p_sig2", sig_o, 32'h0000_0002);
        check("p_cmp_ready", {31'd0, data_ready_o}, 32'd0);
        wait_done(4, 1'b1);

        // Fail case: feedback taps fire on the second word.
        start_session(16'd2, 32'h0);
        send_word(32'h8000_0000, 0, 32'h0);
        check("f_sig1", sig_o, 32'h8000_0000);
        send_word(32'h0000_0000, 0, 32'h0);
        check("f_sig2", sig_o, 32'h0000_8409);
        wait_done(4, 1'b0);

        // Gaps of 0, 2 and 5 idle cycles between words.
        start_session(16'd3, 32'h8000_0004);
        send_word(32'h0000_0001, 0, 32'h0);
        check("g_sig1", sig_o, 32'h0000_0001);
        send_word(32'h0000_0000, 2, 32'h0000_0001);
        check("g_sig2", sig_o, 32'h0000_0002);
        send_word(32'h8000_0000, 5, 32'h0000_0002);
        check("g_sig3", sig_o, 32'h8000_0004);
        wait_done(12, 1'b1);

        // len = 0: words offered during LOAD are ignored.
        start_i  = 1'b1;
        len_i    = 16'd0;
        golden_i = 32'h0;
        step;
        t0           = cyc;
        start_i      = 1'b0;
        data_valid_i = 1'b1;
        data_i       = 32'hFFFF_FFFF;
        step;
        data_valid_i = 1'b0;
        check("z_sig",   sig_o,                 32'h0);
        check("z_ready", {31'd0, data_ready_o}, 32'd0);
        wait_done(2, 1'b1);

        // Abort after 1 of 4 words; start while busy is ignored.
        start_session(16'd4, 32'h0);
        send_word(32'h0000_0005, 0, 32'h0);
        check("a_sig1", sig_o, 32'h0000_0005);
        start_i = 1'b1;
        len_i   = 16'd1;
        step;
        start_i = 1'b0;
        check("a_busy_start", {31'd0, busy_o},       32'd1);
        check("a_ready",      {31'd0, data_ready_o}, 32'd1);
        check("a_sig_hold",   sig_o,                 32'h0000_0005);
        abort_i      = 1'b1;
        data_valid_i = 1'b1;
        data_i       = 32'h0000_00FF;
        step;
        abort_i      = 1'b0;
        data_valid_i = 1'b0;
        check("ab_sig",  sig_o,           32'h0000_0005);
        check("ab_pass", {31'd0, pass_o}, 32'd0);
        check("ab_fail", {31'd0, fail_o}, 32'd0);
        check_idle_outputs("ab");
        for (int i = 0; i < 3; i++) begin
            step;
            check("ab_no_done", {31'd0, done_o}, 32'd0);
        end
        $display("session aborted after 1 of 4 words");

        // Abort while in COMPARE: no verdict and no done.
        start_session(16'd1, 32'h0000_0005);
        send_word(32'h0000_0005, 0, 32'h0);
        check("ac_sig",  sig_o,           32'h0000_0005);
        check("ac_busy", {31'd0, busy_o}, 32'd1);
        abort_i = 1'b1;
        step;
        abort_i = 1'b0;
        check("ac_pass", {31'd0, pass_o}, 32'd0);
        check("ac_fail", {31'd0, fail_o}, 32'd0);
        check_idle_outputs("ac");
        step;
        check("ac_no_done", {31'd0, done_o}, 32'd0);
        $display("session aborted in compare");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
